prog_sequencer: RTL and testbench

//  Top-level program sequencer. Produces the 2-bit ProgState consumed by the exception

---
 rtl/prog_seq_pkg.sv | 32 +++
 rtl/sat_counter.sv | 25 ++
 rtl/prog_sequencer.sv | 136 +++++++++++++
 tb/tb_prog_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared sequencer types: FSM states, ProgState encodings, program count.
// Also used by the exception checker and control, which decode ProgState.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [1:0] PS_IDLE   = 2'b00;
    localparam logic [1:0] PS_P1     = 2'b01;
    localparam logic [1:0] PS_P2     = 2'b10;
    localparam logic [1:0] PS_P3     = 2'b11;
    localparam logic [1:0] NUM_PROGS = 2'd3;

    // One-hot TimeoutMask bit for program p (1..3).
    function automatic logic [2:0] prog_bit(input logic [1:0] p);
        logic [2:0] b;
        b = 3'b000;
        case (p)
            2'd1:    b = 3'b001;
            2'd2:    b = 3'b010;
            2'd3:    b = 3'b100;
            default: b = 3'b000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset/clear and enable; sticks at all-ones.
// One-cycle update latency; no backpressure.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: runs programs 1->2->3 after Start, pulses PCInit with each start PC,
// and ends a program on Halt or on watchdog expiry. Optional PROG_TRACE_EN adds sim trace.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter logic [9:0]  PROG1_ADDR = 10'd0,
    parameter logic [9:0]  PROG2_ADDR = 10'd256,
    parameter logic [9:0]  PROG3_ADDR = 10'd512,
    parameter logic [15:0] MAX_CYCLES = 16'd8192
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Halt,
    output logic [1:0]  ProgState,
    output logic        PCInit,
    output logic [9:0]  StartAddr,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] CycleCount,
    output logic [15:0] LastCount,
    output logic [2:0]  TimeoutMask
);

    state_e      state_q;
    logic [1:0]  prog_q;
    logic [1:0]  prog_state_q;
    logic        pcinit_q;
    logic [9:0]  start_addr_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] last_count_q;
    logic [2:0]  timeout_mask_q;
    logic [15:0] cycle_cnt;
    logic [1:0]  prog_d;

    function automatic logic [9:0] prog_addr(input logic [1:0] p);
        logic [9:0] a;
        a = PROG1_ADDR;
        case (p)
            2'd2:    a = PROG2_ADDR;
            2'd3:    a = PROG3_ADDR;
            default: a = PROG1_ADDR;
        endcase
        return a;
    endfunction

    assign prog_d = prog_q + 2'd1;

    sat_counter #(.WIDTH(16)) u_cycle_cnt (
        .clk_i (CLK),
        .rst_i (Reset),
        .clr_i (state_q == S_INIT),
        .en_i  (state_q == S_RUN),
        .cnt_o (cycle_cnt)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            prog_q         <= 2'd0;
            prog_state_q   <= PS_IDLE;
            pcinit_q       <= 1'b0;
            start_addr_q   <= 10'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            last_count_q   <= 16'd0;
            timeout_mask_q <= 3'b000;
        end else begin
            pcinit_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q        <= S_INIT;
                        prog_q         <= 2'd1;
                        prog_state_q   <= PS_P1;
                        pcinit_q       <= 1'b1;
                        start_addr_q   <= PROG1_ADDR;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        timeout_mask_q <= 3'b000;
                    end
                end
                S_INIT: state_q <= S_RUN;
                S_RUN: begin
                    // Halt takes priority over a watchdog expiry in the same cycle.
                    if (Halt) begin
                        state_q <= S_NEXT;
                    end else if (cycle_cnt == MAX_CYCLES - 16'd1) begin
                        timeout_mask_q <= timeout_mask_q | prog_bit(prog_q);
                        state_q        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    last_count_q <= cycle_cnt;
                    if (prog_q == NUM_PROGS) begin
                        state_q      <= S_DONE;
                        prog_state_q <= PS_IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        state_q      <= S_INIT;
                        prog_q       <= prog_d;
                        prog_state_q <= prog_d;
                        pcinit_q     <= 1'b1;
                        start_addr_q <= prog_addr(prog_d);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PROG_TRACE_EN
    always @(posedge CLK) begin
        if (!Reset && state_q == S_NEXT) begin
            $display("prog %0d %s, LastCount=%0d", prog_q,
                     ((timeout_mask_q & prog_bit(prog_q)) != 3'b000) ? "timed out" : "halted",
                     cycle_cnt);
            if (prog_q == NUM_PROGS) begin
                $display("All programs done");
            end
        end
    end
`endif

    assign ProgState   = prog_state_q;
    assign PCInit      = pcinit_q;
    assign StartAddr   = start_addr_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign CycleCount  = cycle_cnt;
    assign LastCount   = last_count_q;
    assign TimeoutMask = timeout_mask_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a 16-cycle watchdog; outputs sampled 1ns after posedge.
module tb_prog_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Halt;
    logic [1:0]  ProgState;
    logic        PCInit;
    logic [9:0]  StartAddr;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;
    logic [15:0] LastCount;
    logic [2:0]  TimeoutMask;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    prog_sequencer #(
        .PROG1_ADDR (10'd0),
        .PROG2_ADDR (10'd256),
        .PROG3_ADDR (10'd512),
        .MAX_CYCLES (16'd16)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Start       (Start),
        .Halt        (Halt),
        .ProgState   (ProgState),
        .PCInit      (PCInit),
        .StartAddr   (StartAddr),
        .Busy        (Busy),
        .Done        (Done),
        .CycleCount  (CycleCount),
        .LastCount   (LastCount),
        .TimeoutMask (TimeoutMask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // From INIT: run n RUN cycles, Halt during the n-th, then step through NEXT.
    task automatic halt_after(input int n);
        repeat (n) tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0;
        repeat (2) tick();
        chk("rst_progstate", ProgState, 0);
        chk("rst_pcinit", PCInit, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_cycle", CycleCount, 0);
        chk("rst_last", LastCount, 0);
        chk("rst_mask", TimeoutMask, 0);
        Reset = 1'b0;

        // Test 1: start latency
        Start = 1'b1; tick(); Start = 1'b0;
        chk("t1_pcinit", PCInit, 1);
        chk("t1_addr", StartAddr, 0);
        chk("t1_progstate", ProgState, 1);
        chk("t1_busy", Busy, 1);
        tick();
        chk("t1_pcinit_pulse", PCInit, 0);
        chk("t1_cycle0", CycleCount, 0);

        // Test 2: halt on 10th RUN cycle of each program (already one RUN cycle spent)
        halt_after(9);
        chk("t2_last1", LastCount, 10);
        chk("t2_pcinit2", PCInit, 1);
        chk("t2_addr2", StartAddr, 256);
        chk("t2_ps2", ProgState, 2);
        halt_after(10);
        chk("t2_last2", LastCount, 10);
        chk("t2_addr3", StartAddr, 512);
        chk("t2_ps3", ProgState, 3);
        halt_after(10);
        chk("t2_last3", LastCount, 10);
        chk("t2_done", Done, 1);
        chk("t2_busy", Busy, 0);
        chk("t2_ps_idle", ProgState, 0);
        chk("t2_mask", TimeoutMask, 0);

        // Test 3: program 2 times out
        Start = 1'b1; tick(); Start = 1'b0;
        chk("t3_ps1", ProgState, 1);
        chk("t3_done_clr", Done, 0);
        halt_after(5);
        chk("t3_last1", LastCount, 5);
        repeat (16) tick();
        chk("t3_cnt15", CycleCount, 15);
        chk("t3_mask_pre", TimeoutMask, 0);
        tick();
        chk("t3_mask", TimeoutMask, 3'b010);
        chk("t3_next_ps", ProgState, 2);
        tick();
        chk("t3_p3_pcinit", PCInit, 1);
        chk("t3_p3_addr", StartAddr, 512);
        chk("t3_last2", LastCount, 16);

        // Test 4: Halt coincides with the limit in program 3
        repeat (16) tick();
        chk("t4_cnt15", CycleCount, 15);
        Halt = 1'b1; tick(); Halt = 1'b0;
        chk("t4_mask", TimeoutMask, 3'b010);
        tick();
        chk("t4_done", Done, 1);
        chk("t4_last3", LastCount, 16);
        chk("t4_mask_done", TimeoutMask, 3'b010);

        // Test 5: Start ignored in RUN, Reset aborts program 2
        Start = 1'b1; tick(); Start = 1'b0;
        chk("t5_mask_clr", TimeoutMask, 0);
        halt_after(3);
        repeat (3) tick();
        Start = 1'b1; tick(); Start = 1'b0;
        chk("t5_ign_ps", ProgState, 2);
        chk("t5_ign_pcinit", PCInit, 0);
        chk("t5_ign_cnt", CycleCount, 3);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("t5_ps", ProgState, 0);
        chk("t5_busy", Busy, 0);
        chk("t5_cnt", CycleCount, 0);
        chk("t5_last", LastCount, 0);
        chk("t5_mask", TimeoutMask, 0);

        // Test 6: restart from DONE with mask 001, Start held high
        Start = 1'b1; tick(); Start = 1'b0;
        repeat (17) tick();
        tick();
        chk("t6_last1", LastCount, 16);
        halt_after(2);
        halt_after(2);
        chk("t6_done", Done, 1);
        chk("t6_mask_pre", TimeoutMask, 3'b001);
        Start = 1'b1; tick();
        chk("t6_mask", TimeoutMask, 0);
        chk("t6_ps", ProgState, 1);
        chk("t6_pcinit", PCInit, 1);
        chk("t6_done_clr", Done, 0);
        tick(); Start = 1'b0;
        chk("t6_held_pcinit", PCInit, 0);
        chk("t6_held_ps", ProgState, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
